// File: rtl/apb_ppr_pkg.sv
// apb_ppr_pkg: shared types for the PPR sequencer.
// Sequencer states, register addresses and the request-queue entry.
// Entry fields use the widest legal sizes (8 ranks, 8-bit bank, 16-bit
// row) so the package needs no parameters.
package apb_ppr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_CLEAR = 2'd3
  } ppr_state_e;

  localparam logic [7:0] ADDR_CTRL      = 8'h00;
  localparam logic [7:0] ADDR_RANK_SEL  = 8'h03;
  localparam logic [7:0] ADDR_CMD       = 8'h04;
  localparam logic [7:0] ADDR_BANK      = 8'h05;
  localparam logic [7:0] ADDR_ROW_LO    = 8'h06;
  localparam logic [7:0] ADDR_ROW_HI    = 8'h07;
  localparam logic [7:0] ADDR_QSTAT     = 8'h08;
  localparam logic [7:0] ADDR_DONE_STAT = 8'h60;
  localparam logic [7:0] ADDR_FAIL_STAT = 8'h61;
  localparam logic [7:0] ADDR_TMO_STAT  = 8'h62;
  localparam logic [7:0] ADDR_INTR_MASK = 8'h64;

  typedef struct packed {
    logic [2:0]  rank;
    logic [7:0]  bank;
    logic [15:0] row;
  } ppr_req_t;

  // One-hot decode of a rank index, caller keeps the low NB_RANK bits.
  function automatic logic [7:0] rank_onehot(input logic [2:0] idx);
    logic [7:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/ppr_req_fifo.sv
// ppr_req_fifo: synchronous request queue for the PPR sequencer.
// Push is refused while full and pop while empty; flush empties the
// queue and takes priority over push/pop in the same cycle.
module ppr_req_fifo
  import apb_ppr_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int LW   = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  ppr_req_t      push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output ppr_req_t      head_o,
  output logic [LW-1:0] level_o,
  output logic          full_o,
  output logic          empty_o
);

  ppr_req_t        mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            push_ok, pop_ok;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;

  // Pointer and occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok) level_d = level_q + 1'b1;
      if (pop_ok && !push_ok) level_d = level_q - 1'b1;
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Entry storage; contents are don't-care until pushed
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/apb_ppr_seq.sv
// apb_ppr_seq: APB-programmed multi-rank Post-Package-Repair sequencer.
// Software stages rank/bank/row and enqueues with CMD; the sequencer
// issues one request at a time and records done/fail per rank.
// Optional watchdog: define PPR_TIMEOUT_EN to bound the WAIT state.
module apb_ppr_seq
  import apb_ppr_pkg::*;
#(
  parameter int APB_ADDRWIDTH  = 16,
  parameter int APB_DATAWIDTH  = 8,
  parameter int NB_RANK        = 2,
  parameter int BANK_WIDTH     = 5,
  parameter int ROW_WIDTH      = 16,
  parameter int QUEUE_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     pclk_i,
  input  logic                     prst_ni,
  input  logic [APB_ADDRWIDTH-1:0] paddr_i,
  input  logic                     psel_i,
  input  logic                     penable_i,
  input  logic                     pwrite_i,
  input  logic [APB_DATAWIDTH-1:0] pwdata_i,
  input  logic [3:0]               pstrb_i,
  output logic                     pready_o,
  output logic [APB_DATAWIDTH-1:0] prdata_o,
  output logic                     pslverr_o,
  output logic [NB_RANK-1:0]       ppr_en_o,
  output logic [BANK_WIDTH-1:0]    ppr_bank_o,
  output logic [ROW_WIDTH-1:0]     ppr_row_o,
  input  logic [NB_RANK-1:0]       ppr_done_status_i,
  input  logic [NB_RANK-1:0]       ppr_status_i,
  output logic                     mc_intr_o
);

  localparam int LVL_W = $clog2(QUEUE_DEPTH) + 1;

  // Configuration / status registers
  logic                  enable_q, enable_d;
  logic [2:0]            rank_sel_q, rank_sel_d;
  logic [BANK_WIDTH-1:0] bank_q, bank_d;
  logic [ROW_WIDTH-1:0]  row_q, row_d;
  logic [NB_RANK-1:0]    done_stat_q, done_stat_d;
  logic [NB_RANK-1:0]    fail_stat_q, fail_stat_d;
  logic [NB_RANK-1:0]    intr_mask_q, intr_mask_d;
  logic [NB_RANK-1:0]    tmo_stat;
  logic                  intr_q;

  // Sequencer state
  ppr_state_e            state_q;
  logic [NB_RANK-1:0]    ppr_en_q;
  logic [BANK_WIDTH-1:0] ppr_bank_q;
  logic [ROW_WIDTH-1:0]  ppr_row_q;
  logic [NB_RANK-1:0]    cur_oh_q;

  // APB decode
  logic apb_access, apb_wr, apb_rd, wr_strb, wr_ok;
  logic addr_err, val_err;
  logic [7:0] rdata;
  logic [7:0] bank_ext, done_ext, fail_ext, tmo_ext, mask_ext;
  logic [15:0] row_ext, row_wr;

  // Queue interface
  ppr_req_t         push_req, head;
  logic             push, pop, flush;
  logic [LVL_W-1:0] fifo_level;
  logic             fifo_full, fifo_empty;
  logic [3:0]       level4;
  logic [7:0]       head_oh8;
  logic [NB_RANK-1:0] head_oh;

  // Completion / timeout events of the in-flight request
  logic               done_hit, pass_hit, tmo_hit;
  logic [NB_RANK-1:0] done_clr, fail_clr, tmo_clr;
  logic [NB_RANK-1:0] done_set, fail_set, tmo_set;

  assign apb_access = psel_i & penable_i;
  assign apb_wr     = apb_access & pwrite_i;
  assign apb_rd     = apb_access & ~pwrite_i;
  assign wr_strb    = apb_wr & pstrb_i[0];
  assign pready_o   = apb_access;
  assign pslverr_o  = apb_access & (addr_err | val_err);
  assign wr_ok      = wr_strb & ~addr_err & ~val_err;
  assign prdata_o   = apb_rd ? rdata : '0;

  assign done_hit = (state_q == ST_WAIT) && |(ppr_done_status_i & cur_oh_q);
  assign pass_hit = |(ppr_status_i & cur_oh_q);
  assign pop      = (state_q == ST_IDLE) && enable_q && !fifo_empty && !flush;
  assign head_oh8 = rank_onehot(head.rank);
  assign head_oh  = head_oh8[NB_RANK-1:0];

  // Zero-extended views of narrow registers for readback
  always_comb begin
    bank_ext = '0;
    bank_ext[BANK_WIDTH-1:0] = bank_q;
    row_ext  = '0;
    row_ext[ROW_WIDTH-1:0] = row_q;
    done_ext = '0;
    done_ext[NB_RANK-1:0] = done_stat_q;
    fail_ext = '0;
    fail_ext[NB_RANK-1:0] = fail_stat_q;
    tmo_ext  = '0;
    tmo_ext[NB_RANK-1:0] = tmo_stat;
    mask_ext = '0;
    mask_ext[NB_RANK-1:0] = intr_mask_q;
    level4   = '0;
    level4[LVL_W-1:0] = fifo_level;
    push_req = '0;
    push_req.rank = rank_sel_q;
    push_req.bank[BANK_WIDTH-1:0] = bank_q;
    push_req.row[ROW_WIDTH-1:0] = row_q;
  end

  // Address decode, read mux and error detection
  always_comb begin
    addr_err = 1'b0;
    val_err  = 1'b0;
    rdata    = '0;
    case (paddr_i)
      APB_ADDRWIDTH'(ADDR_CTRL):      rdata = {7'b0, enable_q};
      APB_ADDRWIDTH'(ADDR_RANK_SEL): begin
        rdata   = {5'b0, rank_sel_q};
        val_err = wr_strb && (32'(pwdata_i) >= NB_RANK);
      end
      APB_ADDRWIDTH'(ADDR_CMD):       val_err = wr_strb && pwdata_i[0] && fifo_full;
      APB_ADDRWIDTH'(ADDR_BANK):      rdata = bank_ext;
      APB_ADDRWIDTH'(ADDR_ROW_LO):    rdata = row_ext[7:0];
      APB_ADDRWIDTH'(ADDR_ROW_HI):    rdata = row_ext[15:8];
      APB_ADDRWIDTH'(ADDR_QSTAT): begin
        rdata   = {fifo_full, (state_q != ST_IDLE), 2'b00, level4};
        val_err = wr_strb;
      end
      APB_ADDRWIDTH'(ADDR_DONE_STAT): rdata = done_ext;
      APB_ADDRWIDTH'(ADDR_FAIL_STAT): rdata = fail_ext;
      APB_ADDRWIDTH'(ADDR_TMO_STAT):  rdata = tmo_ext;
      APB_ADDRWIDTH'(ADDR_INTR_MASK): rdata = mask_ext;
      default:                        addr_err = 1'b1;
    endcase
  end

  // Register write commit and status set/clear (hardware set wins)
  always_comb begin
    enable_d    = enable_q;
    rank_sel_d  = rank_sel_q;
    bank_d      = bank_q;
    row_d       = row_q;
    intr_mask_d = intr_mask_q;
    row_wr      = row_ext;
    push        = 1'b0;
    flush       = 1'b0;
    done_clr    = '0;
    fail_clr    = '0;
    tmo_clr     = '0;
    if (wr_ok) begin
      case (paddr_i)
        APB_ADDRWIDTH'(ADDR_CTRL): begin
          enable_d = pwdata_i[0];
          flush    = pwdata_i[1];
        end
        APB_ADDRWIDTH'(ADDR_RANK_SEL):  rank_sel_d = pwdata_i[2:0];
        APB_ADDRWIDTH'(ADDR_CMD):       push = pwdata_i[0];
        APB_ADDRWIDTH'(ADDR_BANK):      bank_d = pwdata_i[BANK_WIDTH-1:0];
        APB_ADDRWIDTH'(ADDR_ROW_LO): begin
          row_wr[7:0] = pwdata_i;
          row_d       = row_wr[ROW_WIDTH-1:0];
        end
        APB_ADDRWIDTH'(ADDR_ROW_HI): begin
          row_wr[15:8] = pwdata_i;
          row_d        = row_wr[ROW_WIDTH-1:0];
        end
        APB_ADDRWIDTH'(ADDR_DONE_STAT): done_clr = pwdata_i[NB_RANK-1:0];
        APB_ADDRWIDTH'(ADDR_FAIL_STAT): fail_clr = pwdata_i[NB_RANK-1:0];
        APB_ADDRWIDTH'(ADDR_TMO_STAT):  tmo_clr = pwdata_i[NB_RANK-1:0];
        APB_ADDRWIDTH'(ADDR_INTR_MASK): intr_mask_d = pwdata_i[NB_RANK-1:0];
        default: ;
      endcase
    end
    done_set    = done_hit ? cur_oh_q : '0;
    fail_set    = ((done_hit && !pass_hit) || tmo_hit) ? cur_oh_q : '0;
    tmo_set     = tmo_hit ? cur_oh_q : '0;
    done_stat_d = (done_stat_q & ~done_clr) | done_set;
    fail_stat_d = (fail_stat_q & ~fail_clr) | fail_set;
  end

  // Software-visible registers and the interrupt flop
  always_ff @(posedge pclk_i or negedge prst_ni) begin
    if (!prst_ni) begin
      enable_q    <= 1'b0;
      rank_sel_q  <= '0;
      bank_q      <= '0;
      row_q       <= '0;
      done_stat_q <= '0;
      fail_stat_q <= '0;
      intr_mask_q <= '0;
      intr_q      <= 1'b0;
    end else begin
      enable_q    <= enable_d;
      rank_sel_q  <= rank_sel_d;
      bank_q      <= bank_d;
      row_q       <= row_d;
      done_stat_q <= done_stat_d;
      fail_stat_q <= fail_stat_d;
      intr_mask_q <= intr_mask_d;
      intr_q      <= |((done_stat_q | tmo_stat) & ~intr_mask_q);
    end
  end

`ifdef PPR_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TMO_W-1:0]   tmo_cnt_q;
  logic [NB_RANK-1:0] tmo_stat_q;

  assign tmo_hit  = (state_q == ST_WAIT) && !done_hit &&
                    (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
  assign tmo_stat = tmo_stat_q;

  // Watchdog: restarts at each issue, counts WAIT cycles; TMO_STAT flops
  always_ff @(posedge pclk_i or negedge prst_ni) begin
    if (!prst_ni) begin
      tmo_cnt_q  <= '0;
      tmo_stat_q <= '0;
    end else begin
      if (state_q == ST_ISSUE)     tmo_cnt_q <= '0;
      else if (state_q == ST_WAIT) tmo_cnt_q <= tmo_cnt_q + 1'b1;
      tmo_stat_q <= (tmo_stat_q & ~tmo_clr) | tmo_set;
    end
  end
`else
  assign tmo_hit  = 1'b0;
  assign tmo_stat = '0;
`endif

  // Sequencer FSM: pop, issue, wait for done (or timeout), one-cycle gap
  always_ff @(posedge pclk_i or negedge prst_ni) begin
    if (!prst_ni) begin
      state_q    <= ST_IDLE;
      ppr_en_q   <= '0;
      ppr_bank_q <= '0;
      ppr_row_q  <= '0;
      cur_oh_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            state_q    <= ST_ISSUE;
            ppr_bank_q <= head.bank[BANK_WIDTH-1:0];
            ppr_row_q  <= head.row[ROW_WIDTH-1:0];
            cur_oh_q   <= head_oh;
          end
        end
        ST_ISSUE: begin
          state_q  <= ST_WAIT;
          ppr_en_q <= cur_oh_q;
        end
        ST_WAIT: begin
          if (done_hit || tmo_hit) begin
            state_q  <= ST_CLEAR;
            ppr_en_q <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ppr_en_o   = ppr_en_q;
  assign ppr_bank_o = ppr_bank_q;
  assign ppr_row_o  = ppr_row_q;
  assign mc_intr_o  = intr_q;

  ppr_req_fifo #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk_i       (pclk_i),
    .rst_ni      (prst_ni),
    .push_i      (push),
    .push_data_i (push_req),
    .pop_i       (pop),
    .flush_i     (flush),
    .head_o      (head),
    .level_o     (fifo_level),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // Bits that exist only for the widest configuration
  logic unused_bits;
  assign unused_bits = ^{pstrb_i[3:1], head, head_oh8, row_wr, tmo_clr, tmo_set};

endmodule
